pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. Drives the write-enable and flush controls of the PC, IF/ID and ID/EX registers, and the EX/MEM advance enable. Resolves load-use stalls, EX-stage redirects, multi-cycle data-memory waits and ecall/ebreak halt drain. Keeps saturating stall/flush performance counters and a memory-timeout error flag.

---
 rtl/rv32_pipe_pkg.sv | 33 +++
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/load_use_detect.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pipe_pkg
//  Description : Shared types and constants for the RV32I pipeline control
//                logic (sequencing states, perf counter width, x0 index).
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pipe_pkg;

    // Sequencing controller states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

    // Width of the stall / flush performance counters
    localparam int PERF_W = 32;

    // Architectural zero register; never a real hazard source
    localparam logic [4:0] X0 = 5'd0;

    // Saturation value for the perf counters
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping to zero
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == PERF_MAX) ? v : v + PERF_W'(1);
    endfunction

endpackage : rv32_pipe_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the 5-stage datapath and the pipeline
//                sequencing controller. The datapath side (master) supplies
//                hazard information; the controller side (slave) returns
//                register enables, flushes, status and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    import rv32_pipe_pkg::*;

    // Hazard information from the datapath
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_memread;
    logic [4:0]        ex_rd;
    logic              ex_redirect;
    logic              ex_halt;
    logic              mem_req;
    logic              mem_ready;

    // Pipeline register controls and status back to the datapath
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_write;
    logic              halted;
    logic              timeout_err;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Datapath view
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_memread, ex_rd, ex_redirect, ex_halt,
               mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
               halted, timeout_err, stall_cnt, flush_cnt
    );

    // Controller view
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_memread, ex_rd, ex_redirect, ex_halt,
               mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
               halted, timeout_err, stall_cnt, flush_cnt
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use compare. Flags when the instruction
//                in ID reads a register that the load currently in EX will
//                write. Shared with the forwarding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import rv32_pipe_pkg::*;
(
    input  wire [4:0] i_id_rs1,
    input  wire [4:0] i_id_rs2,
    input  wire       i_id_use_rs1,
    input  wire       i_id_use_rs2,
    input  wire       i_ex_memread,
    input  wire [4:0] i_ex_rd,
    output logic      o_lu
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // A source only matters if the ID instruction actually reads it
    assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

    // Loads into x0 are discarded, so they never create a dependency
    assign o_lu = i_ex_memread && (i_ex_rd != X0) && (w_rs1_hit || w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline sequencing controller for the 5-stage RV32I core.
//                Resolves load-use stalls, EX redirects, data-memory waits
//                and ecall/ebreak halt drain. Controls are Mealy outputs of
//                the state and current hazard inputs. Keeps saturating
//                stall / flush counters and a sticky memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int MAX_WAIT     = 255,
    parameter int DRAIN_CYCLES = 2
) (
    input  wire               clk,
    input  wire               rst,
    pipe_hazard_ctrl_if.slave bus
);

    // ------------------------------------------------------------------
    // Counter sizing: just wide enough to hold the terminal value
    // ------------------------------------------------------------------
    localparam int c_wait_w  = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int c_drain_w = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [c_wait_w-1:0]  c_wait_max  = c_wait_w'(MAX_WAIT);
    localparam logic [c_drain_w-1:0] c_drain_end = c_drain_w'(DRAIN_CYCLES);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    ctrl_state_t          r_state_q;
    ctrl_state_t          w_state_d;
    logic [c_wait_w-1:0]  r_wait_q;
    logic [c_wait_w-1:0]  w_wait_d;
    logic [c_drain_w-1:0] r_drain_q;
    logic [c_drain_w-1:0] w_drain_d;
    logic [PERF_W-1:0]    r_stall_cnt_q;
    logic [PERF_W-1:0]    w_stall_cnt_d;
    logic [PERF_W-1:0]    r_flush_cnt_q;
    logic [PERF_W-1:0]    w_flush_cnt_d;
    logic                 r_timeout_q;
    logic                 w_timeout_d;

    // ------------------------------------------------------------------
    // Hazard terms and decoded controls
    // ------------------------------------------------------------------
    logic w_lu;
    logic w_mstall;
    logic w_freeze;      // full pipeline freeze for an outstanding access
    logic w_run_decode;  // apply the halt / redirect / load-use / normal rows
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_write;

    load_use_detect u_load_use_detect (
        .i_id_rs1     (bus.id_rs1),
        .i_id_rs2     (bus.id_rs2),
        .i_id_use_rs1 (bus.id_use_rs1),
        .i_id_use_rs2 (bus.id_use_rs2),
        .i_ex_memread (bus.ex_memread),
        .i_ex_rd      (bus.ex_rd),
        .o_lu         (w_lu)
    );

    assign w_mstall = bus.mem_req && !bus.mem_ready;

    // Next-state, counter updates and Mealy control decode
    always_comb begin
        w_state_d     = r_state_q;
        w_wait_d      = r_wait_q;
        w_drain_d     = r_drain_q;
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        w_timeout_d   = r_timeout_q;
        w_freeze      = 1'b0;
        w_run_decode  = 1'b0;
        // Safe default: nothing advances, younger stages are cleared
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_write = 1'b0;

        case (r_state_q)
            RUN: begin
                if (w_mstall) begin
                    // First cycle of a memory wait already counts as one
                    w_freeze  = 1'b1;
                    w_state_d = MEM_WAIT;
                    w_wait_d  = c_wait_w'(1);
                end else begin
                    w_run_decode = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    w_freeze = 1'b1;
                    w_wait_d = (r_wait_q >= c_wait_max) ? r_wait_q
                                                        : r_wait_q + c_wait_w'(1);
                end else begin
                    // Release cycle behaves exactly like a RUN cycle with no
                    // memory stall; a held redirect/halt is acted on here
                    w_run_decode = 1'b1;
                    w_state_d    = RUN;
                end
            end

            DRAIN: begin
                // Older instructions retire; nothing new enters the pipe
                w_exmem_write = !w_mstall;
                if (!w_mstall) begin
                    w_drain_d = r_drain_q + c_drain_w'(1);
                    if (w_drain_d >= c_drain_end) begin
                        w_state_d = HALTED;
                    end
                end
            end

            HALTED: begin
                // Parked until reset; safe defaults already apply
            end

            default: begin
                w_state_d = RUN;
            end
        endcase

        if (w_freeze) begin
            // Whole pipe holds; flushing here would lose held instructions
            w_ifid_flush  = 1'b0;
            w_idex_flush  = 1'b0;
            w_stall_cnt_d = sat_inc(r_stall_cnt_q);
            if (w_wait_d >= c_wait_max) begin
                w_timeout_d = 1'b1;
            end
        end

        if (w_run_decode) begin
            if (bus.ex_halt) begin
                // Halt beats redirect: the redirect target is never fetched
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
                w_exmem_write = 1'b1;
                w_state_d     = DRAIN;
                w_drain_d     = '0;
            end else if (bus.ex_redirect) begin
                // Redirect beats load-use: the dependent instruction is
                // on the wrong path and gets squashed anyway
                w_pc_write    = 1'b1;
                w_ifid_write  = 1'b1;
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
                w_exmem_write = 1'b1;
                w_flush_cnt_d = sat_inc(r_flush_cnt_q);
            end else if (w_lu) begin
                // Hold PC and IF/ID one cycle, bubble into EX
                w_pc_write    = 1'b0;
                w_ifid_write  = 1'b0;
                w_ifid_flush  = 1'b0;
                w_idex_flush  = 1'b1;
                w_exmem_write = 1'b1;
                w_stall_cnt_d = sat_inc(r_stall_cnt_q);
            end else begin
                w_pc_write    = 1'b1;
                w_ifid_write  = 1'b1;
                w_ifid_flush  = 1'b0;
                w_idex_flush  = 1'b0;
                w_exmem_write = 1'b1;
            end
        end
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= RUN;
            r_wait_q      <= '0;
            r_drain_q     <= '0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
            r_timeout_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_wait_q      <= w_wait_d;
            r_drain_q     <= w_drain_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
            r_timeout_q   <= w_timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: reset overrides the decode immediately so the pipe is held
    // and cleared while reset is asserted, independent of the clock
    // ------------------------------------------------------------------
    assign bus.pc_write    = w_pc_write    & ~rst;
    assign bus.ifid_write  = w_ifid_write  & ~rst;
    assign bus.exmem_write = w_exmem_write & ~rst;
    assign bus.ifid_flush  = w_ifid_flush  |  rst;
    assign bus.idex_flush  = w_idex_flush  |  rst;
    assign bus.halted      = (r_state_q == HALTED);
    assign bus.timeout_err = r_timeout_q;
    assign bus.stall_cnt   = r_stall_cnt_q;
    assign bus.flush_cnt   = r_flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl
//                (MAX_WAIT=4, DRAIN_CYCLES=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MAX_WAIT(4), .DRAIN_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write}
    wire [4:0] ctl5 = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.exmem_write};
    // {pc_write, ifid_flush, idex_flush, exmem_write}
    wire [3:0] ctl4 = {bus.pc_write, bus.ifid_flush, bus.idex_flush, bus.exmem_write};

    localparam logic [4:0] C_NORMAL = 5'b11001;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_LU     = 5'b00011;
    localparam logic [4:0] C_DRAIN  = 5'b00111;
    localparam logic [4:0] C_HOLD   = 5'b00110;
    localparam logic [3:0] C_HALT4  = 4'b0111;
    localparam logic [3:0] C_REDIR4 = 4'b1111;

    task automatic idle();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_memread = 1'b0; bus.ex_rd = 5'd0;
        bus.ex_redirect = 1'b0; bus.ex_halt = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        #1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        if (ctl5 !== C_HOLD) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl5, C_HOLD); end
        total++;
        if ({bus.halted, bus.timeout_err} !== 2'b00) begin bad++; $display("FAIL reset_status: got %b want 00", {bus.halted, bus.timeout_err}); end
        total++;
        if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
        total++;
        step();
        rst = 1'b0;
        #2;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL reset_release_ctl: got %b want %b", ctl5, C_NORMAL); end
        total++;
    endtask

    task automatic test_load_use();
        apply_reset();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
        #2;
        if (ctl5 !== C_LU) begin bad++; $display("FAIL lu_rs1_ctl: got %b want %b", ctl5, C_LU); end
        total++;
        step();
        bus.ex_memread = 1'b0;
        #2;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL lu_after_ctl: got %b want %b", ctl5, C_NORMAL); end
        total++;
        if (bus.stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
        total++;
        // Load into x0 never stalls
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
        #2;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL lu_x0_ctl: got %b want %b", ctl5, C_NORMAL); end
        total++;
        step();
        // Match on rs2
        bus.ex_rd = 5'd7; bus.id_use_rs1 = 1'b0; bus.id_rs1 = 5'd7; bus.id_use_rs2 = 1'b1; bus.id_rs2 = 5'd7;
        #2;
        if (ctl5 !== C_LU) begin bad++; $display("FAIL lu_rs2_ctl: got %b want %b", ctl5, C_LU); end
        total++;
        step();
        // Register matches but is not read
        bus.id_use_rs2 = 1'b0;
        #2;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL lu_unused_ctl: got %b want %b", ctl5, C_NORMAL); end
        total++;
        step();
        if (bus.stall_cnt !== 32'd2) begin bad++; $display("FAIL lu_stall_cnt2: got %0d want 2", bus.stall_cnt); end
        total++;
    endtask

    task automatic test_redirect_over_lu();
        apply_reset();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd9; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd9;
        bus.ex_redirect = 1'b1;
        #2;
        if (ctl4 !== C_REDIR4) begin bad++; $display("FAIL redir_lu_ctl: got %b want %b", ctl4, C_REDIR4); end
        total++;
        step();
        idle();
        #2;
        if (bus.flush_cnt !== 32'd1 || bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL redir_lu_cnt: got flush=%0d stall=%0d want 1/0", bus.flush_cnt, bus.stall_cnt); end
        total++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            if (ctl5 !== C_FREEZE) begin bad++; $display("FAIL memwait_freeze%0d: got %b want %b", i, ctl5, C_FREEZE); end
            total++;
            step();
        end
        bus.mem_ready = 1'b1;
        #2;
        if (ctl4 !== C_REDIR4) begin bad++; $display("FAIL memwait_release: got %b want %b", ctl4, C_REDIR4); end
        total++;
        step();
        idle();
        #2;
        if (bus.stall_cnt !== 32'd3 || bus.flush_cnt !== 32'd1) begin bad++; $display("FAIL memwait_cnt: got stall=%0d flush=%0d want 3/1", bus.stall_cnt, bus.flush_cnt); end
        total++;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL memwait_back_run: got %b want %b", ctl5, C_NORMAL); end
        total++;
        // Ready in the request cycle: no stall at all
        bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        #2;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL memwait_zero_ctl: got %b want %b", ctl5, C_NORMAL); end
        total++;
        step();
        idle();
        if (bus.stall_cnt !== 32'd3) begin bad++; $display("FAIL memwait_zero_cnt: got %0d want 3", bus.stall_cnt); end
        total++;
    endtask

    task automatic test_timeout();
        apply_reset();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            #1;
            if (bus.timeout_err !== (i >= 4)) begin bad++; $display("FAIL timeout_after%0d: got %b want %b", i, bus.timeout_err, (i >= 4)); end
            total++;
            if (ctl5 !== C_FREEZE) begin bad++; $display("FAIL timeout_freeze%0d: got %b want %b", i, ctl5, C_FREEZE); end
            total++;
        end
        bus.mem_ready = 1'b1;
        #1;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL timeout_release: got %b want %b", ctl5, C_NORMAL); end
        total++;
        step();
        idle();
        #2;
        if (ctl5 !== C_NORMAL || bus.timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got ctl=%b err=%b want %b/1", ctl5, bus.timeout_err, C_NORMAL); end
        total++;
        if (bus.stall_cnt !== 32'd6) begin bad++; $display("FAIL timeout_stall_cnt: got %0d want 6", bus.stall_cnt); end
        total++;
    endtask

    task automatic test_halt_drain();
        apply_reset();
        bus.ex_halt = 1'b1; bus.ex_redirect = 1'b1;
        #2;
        if (ctl4 !== C_HALT4) begin bad++; $display("FAIL halt_entry: got %b want %b", ctl4, C_HALT4); end
        total++;
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            #2;
            if (ctl5 !== C_DRAIN || bus.halted !== 1'b0) begin bad++; $display("FAIL halt_drain%0d: got ctl=%b halted=%b want %b/0", i, ctl5, bus.halted, C_DRAIN); end
            total++;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            #2;
            if (ctl5 !== C_HOLD || bus.halted !== 1'b1) begin bad++; $display("FAIL halt_parked%0d: got ctl=%b halted=%b want %b/1", i, ctl5, bus.halted, C_HOLD); end
            total++;
            step();
        end
        if (bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL halt_flush_cnt: got %0d want 0", bus.flush_cnt); end
        total++;
    endtask

    task automatic test_halt_mem_stall();
        apply_reset();
        bus.ex_halt = 1'b1;
        step();
        idle();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            if (ctl5 !== C_HOLD || bus.halted !== 1'b0) begin bad++; $display("FAIL drainstall%0d: got ctl=%b halted=%b want %b/0", i, ctl5, bus.halted, C_HOLD); end
            total++;
            step();
        end
        bus.mem_req = 1'b0;
        step();
        #1;
        if (bus.halted !== 1'b0) begin bad++; $display("FAIL drainstall_early: got %b want 0", bus.halted); end
        total++;
        step();
        #1;
        if (bus.halted !== 1'b1) begin bad++; $display("FAIL drainstall_halted: got %b want 1", bus.halted); end
        total++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.ex_redirect = 1'b1;
        step();
        idle();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        if (bus.timeout_err !== 1'b1 || bus.stall_cnt !== 32'd4 || bus.flush_cnt !== 32'd1) begin bad++; $display("FAIL areset_pre: got err=%b stall=%0d flush=%0d want 1/4/1", bus.timeout_err, bus.stall_cnt, bus.flush_cnt); end
        total++;
        rst = 1'b1;
        #1;
        if (bus.timeout_err !== 1'b0 || bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL areset_cnt: got err=%b stall=%0d flush=%0d want 0/0/0", bus.timeout_err, bus.stall_cnt, bus.flush_cnt); end
        total++;
        if (ctl5 !== C_HOLD) begin bad++; $display("FAIL areset_ctl: got %b want %b", ctl5, C_HOLD); end
        total++;
        idle();
        step();
        rst = 1'b0;
        #2;
        if (ctl5 !== C_NORMAL) begin bad++; $display("FAIL areset_release: got %b want %b", ctl5, C_NORMAL); end
        total++;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_redirect_over_lu();
        test_mem_wait();
        test_timeout();
        test_halt_drain();
        test_halt_mem_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
